dma_copy_engine: RTL and testbench



---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_copy_engine_if.sv | 15 +
 rtl/dma_copy_engine.sv | 122 ++++++++++++
 tb/tb_dma_copy_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: engine state encoding, config register map and CTRL bit positions.
package dma_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } dma_state_e;

    localparam int DMA_REG_SRC     = 0;
    localparam int DMA_REG_DST     = 1;
    localparam int DMA_REG_CTRL    = 2;
    localparam int DMA_CTRL_START  = 31;
    localparam int DMA_CTRL_IRQ_EN = 30;
    localparam int DMA_LEN_W       = 16;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/dma_copy_engine_if.sv
// DATA_BUS: single-outstanding req/gnt bus, every granted access answered by one rvalid.
interface DATA_BUS;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport Master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
    modport Slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dma_copy_engine.sv
// Word-copy DMA engine: read one word from SRC, write it to DST, repeat LEN times.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int LEN_W = DMA_LEN_W,
    parameter int N_CFG = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CFG-1:0][31:0] cfg_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  irq_o,
    DATA_BUS.Master               dmst
);
    dma_state_e       state_q, state_d;
    logic             start_q;
    logic [31:0]      src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             irq_en_q, irq_en_d, err_q, err_d, irq_q, irq_d;
    logic             start_edge;

    logic unused_cfg;
    assign unused_cfg = ^cfg_i[DMA_REG_CTRL][DMA_CTRL_IRQ_EN-1:LEN_W];

    assign start_edge = cfg_i[DMA_REG_CTRL][DMA_CTRL_START] & ~start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            irq_en_q <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= cfg_i[DMA_REG_CTRL][DMA_CTRL_START];
            src_q    <= src_d;
            dst_q    <= dst_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            irq_en_q <= irq_en_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        irq_en_d = irq_en_q;
        err_d    = err_q;
        irq_d    = irq_q;
        case (state_q)
            IDLE: begin
                // Start edges outside IDLE fall through here unhandled, so they are dropped.
                if (start_edge) begin
                    src_d    = word_align(cfg_i[DMA_REG_SRC]);
                    dst_d    = word_align(cfg_i[DMA_REG_DST]);
                    cnt_d    = cfg_i[DMA_REG_CTRL][LEN_W-1:0];
                    irq_en_d = cfg_i[DMA_REG_CTRL][DMA_CTRL_IRQ_EN];
                    err_d    = 1'b0;
                    irq_d    = 1'b0;
                    state_d  = (cfg_i[DMA_REG_CTRL][LEN_W-1:0] == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: if (dmst.gnt) state_d = RD_WAIT;
            RD_WAIT: begin
                if (dmst.rvalid) begin
                    buf_d = dmst.rdata;
                    if (dmst.err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: if (dmst.gnt) state_d = WR_WAIT;
            WR_WAIT: begin
                if (dmst.rvalid) begin
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (dmst.err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                if (irq_en_q) irq_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decode from registered state only, so they hold steady until gnt.
    assign dmst.req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign dmst.we    = (state_q == WR_REQ);
    assign dmst.addr  = (state_q == WR_REQ) ? dst_q : src_q;
    assign dmst.be    = 4'hF;
    assign dmst.wdata = buf_q;

    assign busy_o = (state_q != IDLE) && (state_q != DONE);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;
    assign irq_o  = irq_q;
endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench: jobs push expected bus accesses and completions; a monitor checks what the engine emits.
module tb_dma_copy_engine;
    import dma_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][31:0] cfg;
    logic             busy, done, err, irq;

    always #5 clk = ~clk;

    DATA_BUS bus ();

    dma_copy_engine #(.LEN_W(16), .N_CFG(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .cfg_i  (cfg),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err),
        .irq_o  (irq),
        .dmst   (bus)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct { logic err; logic irq; } dn_t;

    txn_t exp_q[$];
    dn_t  dn_q[$];
    int   tests = 0;
    int   fails = 0;

    int gnt_dly = 0, rv_dly = 0, err_idx = -1, txn_cnt = 0, wcnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not matched", name);
    endtask

    // Memory slave: programmable gnt and rvalid delays, error on a chosen access.
    initial begin
        bit pend;
        int rcnt;
        logic pwe;
        logic [31:0] paddr;
        pend = 0; rcnt = 0; pwe = 0; paddr = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0; bus.err = 0;
        forever begin
            @(negedge clk);
            bus.gnt = 0; bus.rvalid = 0; bus.err = 0;
            if (rst) begin
                pend = 0;
                wcnt = gnt_dly;
            end else if (pend) begin
                if (rcnt == 0) begin
                    bus.rvalid = 1;
                    bus.rdata  = pwe ? $urandom : mem_word(paddr);
                    bus.err    = (txn_cnt == err_idx);
                    pend = 0;
                    txn_cnt++;
                    wcnt = gnt_dly;
                end else rcnt--;
            end else if (bus.req) begin
                if (wcnt == 0) begin
                    bus.gnt = 1;
                    pend = 1;
                    pwe = bus.we;
                    paddr = bus.addr;
                    rcnt = rv_dly;
                end else wcnt--;
            end
        end
    end

    // Monitor: pops the scoreboard on every granted access and every done pulse.
    initial begin
        bit pv, irq_chk;
        logic pw, irq_exp;
        logic [31:0] pa, pd;
        txn_t t;
        dn_t d;
        pv = 0; irq_chk = 0; pw = 0; irq_exp = 0; pa = 0; pd = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                pv = 0; irq_chk = 0;
                continue;
            end
            if (irq_chk) begin
                chk("irq_after_done", 64'(irq), 64'(irq_exp));
                irq_chk = 0;
            end
            if (bus.req && pv)
                chk("req_stable", {bus.we, bus.addr, bus.wdata}, {pw, pa, pd});
            if (bus.req && bus.gnt) begin
                if (exp_q.size() == 0) fail("unexpected_txn");
                else begin
                    t = exp_q.pop_front();
                    chk("txn_we", 64'(bus.we), 64'(t.we));
                    chk("txn_addr", 64'(bus.addr), 64'(t.addr));
                    chk("txn_be", 64'(bus.be), 64'hF);
                    if (t.we) chk("txn_wdata", 64'(bus.wdata), 64'(t.data));
                end
                pv = 0;
            end else if (bus.req) begin
                pv = 1; pw = bus.we; pa = bus.addr; pd = bus.wdata;
            end else pv = 0;
            if (done) begin
                if (dn_q.size() == 0) fail("unexpected_done");
                else begin
                    d = dn_q.pop_front();
                    chk("done_err", 64'(err), 64'(d.err));
                    chk("done_busy", 64'(busy), 64'd0);
                    irq_chk = 1;
                    irq_exp = d.irq;
                end
            end
        end
    end

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit ien, input int eidx, input int gd, input int rd,
                           input int restart_at);
        logic [31:0] s, d, ra, wa;
        int k, first_req, done_cyc;
        bit has_err;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        k = 0;
        for (int i = 0; i < len; i++) begin
            ra = s + 32'(4 * i);
            wa = d + 32'(4 * i);
            exp_q.push_back('{1'b0, ra, 32'h0});
            if (k == eidx) break;
            k++;
            exp_q.push_back('{1'b1, wa, mem_word(ra)});
            if (k == eidx) break;
            k++;
        end
        has_err = (eidx >= 0) && (eidx < 2 * len);
        dn_q.push_back('{has_err, ien});
        gnt_dly = gd; rv_dly = rd; err_idx = eidx; txn_cnt = 0; wcnt = gd;
        first_req = -1; done_cyc = -1;
        @(negedge clk); #2;
        cfg[0] = src;
        cfg[1] = dst;
        cfg[2] = {1'b1, ien, 14'h0, 16'(len)};
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk); #1;
            if (n == 1) begin
                chk("start_clr_err", 64'(err), 64'd0);
                chk("start_clr_irq", 64'(irq), 64'd0);
            end
            if (bus.req && first_req < 0) first_req = n;
            if (done) begin
                done_cyc = n;
                break;
            end
            if (restart_at > 0 && n == restart_at) begin
                #1 cfg[2][31] = 1'b0;
            end
            if (restart_at > 0 && n == restart_at + 1) begin
                #1 cfg = {1'b1, 15'h0, 16'(1 + $urandom_range(0, 7)), 32'($urandom), 32'($urandom)};
            end
        end
        if (done_cyc < 0) begin
            fail("done_timeout");
            exp_q.delete();
            dn_q.delete();
        end else if (gd == 0 && rd == 0 && !has_err) begin
            if (len == 0) begin
                chk("len0_no_req", 64'(first_req), -64'sd1);
                chk("len0_done_lat", 64'(done_cyc), 64'd1);
            end else begin
                chk("start_lat", 64'(first_req), 64'd1);
                chk("done_lat", 64'(done_cyc), 64'(4 * len + 1));
            end
        end
        repeat (3) @(negedge clk);
        #1;
        chk("txn_all_seen", 64'(exp_q.size()), 64'd0);
        chk("err_sticky", 64'(err), 64'(has_err));
        chk("irq_level", 64'(irq), 64'(ien));
        chk("idle_busy", 64'(busy), 64'd0);
        #1 cfg[2][31] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_transfer();
        bit seen, dn_seen;
        seen = 0; dn_seen = 0;
        exp_q.push_back('{1'b0, 32'h9000, 32'h0});
        exp_q.push_back('{1'b1, 32'hA000, mem_word(32'h9000)});
        dn_q.push_back('{1'b0, 1'b1});
        gnt_dly = 3; rv_dly = 0; err_idx = -1; txn_cnt = 0; wcnt = 3;
        @(negedge clk); #2;
        cfg = {1'b1, 1'b1, 14'h0, 16'd3, 32'hA000, 32'h9000};
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (bus.req && bus.we && !bus.gnt) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail("reach_wr_req");
        #1;
        rst = 1'b1;
        exp_q.delete();
        dn_q.delete();
        cfg[2][31] = 1'b0;
        @(negedge clk); #1;
        chk("rst_req", 64'(bus.req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            if (done || bus.req) dn_seen = 1;
        end
        chk("rst_no_activity", 64'(dn_seen), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rs, rdst;
        int rl, re;
        rst = 1'b1;
        cfg = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req", 64'(bus.req), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        #1 rst = 1'b0;

        run_job(32'h0000_1000, 32'h0000_2000, 3, 1'b0, -1, 0, 0, 0);
        run_job(32'h0000_0000, 32'h0000_0000, 0, 1'b1, -1, 0, 0, 0);
        run_job(32'hFFFF_FFFE, 32'h0000_0103, 2, 1'b0, -1, 0, 0, 0);
        run_job(32'h0000_3000, 32'h0000_4000, 3, 1'b1, -1, 2, 3, 5);
        run_job(32'h0000_5000, 32'h0000_6000, 4, 1'b0, 2, 0, 0, 0);
        run_job(32'h0000_7000, 32'h0000_8000, 1, 1'b0, -1, 0, 0, 0);
        reset_mid_transfer();

        for (int j = 0; j < 20; j++) begin
            rs   = $urandom;
            rdst = $urandom;
            if ($urandom_range(0, 3) == 0) rs = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            rl = $urandom_range(0, 5);
            re = (rl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * rl - 1) : -1;
            run_job(rs, rdst, rl, 1'($urandom_range(0, 1)), re,
                    $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
